traffic_phase_ctrl: RTL and testbench

Phase scheduler for a two-road intersection: main road and side road. It sequences both sets of red/yellow/green lamps through a fixed six-phase cycle, timed by a prescaled tick. Main green is held until a side-road vehicle sensor or a pedestrian button raises demand. It also drives a two-digit BCD countdown of the ticks remaining in the current phase for the board's seven-segment display.

---
 rtl/traffic_phase_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase scheduler with prescaled tick and BCD countdown of ticks left in the phase.
// Pedestrian path (ped_req synchronizer, ped_pend, walk lamp) is built only when TRAFFIC_PED_EN is defined.
module traffic_phase_ctrl #(
  parameter int TICK_DIV     = 20000000,
  parameter int MAIN_GREEN_T = 45,
  parameter int YELLOW_T     = 8,
  parameter int ALL_RED_T    = 2,
  parameter int SIDE_GREEN_T = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       x,
  input  logic       ped_req,
  output logic [2:0] main_lamp,
  output logic [2:0] side_lamp,
  output logic       walk,
  output logic [2:0] phase,
  output logic [3:0] num,
  output logic [3:0] num1
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED1   = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED2   = 3'd5
  } phase_t;

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  localparam int               DIV_W       = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]       BCD_MAIN_G  = to_bcd(MAIN_GREEN_T);
  localparam logic [7:0]       BCD_YELLOW  = to_bcd(YELLOW_T);
  localparam logic [7:0]       BCD_ALL_RED = to_bcd(ALL_RED_T);
  localparam logic [7:0]       BCD_SIDE_G  = to_bcd(SIDE_GREEN_T);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  function automatic logic [7:0] phase_len(input phase_t p);
    case (p)
      MAIN_Y, SIDE_Y: phase_len = BCD_YELLOW;
      RED1, RED2:     phase_len = BCD_ALL_RED;
      SIDE_G:         phase_len = BCD_SIDE_G;
      default:        phase_len = BCD_MAIN_G;
    endcase
  endfunction

  function automatic phase_t phase_succ(input phase_t p);
    case (p)
      MAIN_G:  phase_succ = MAIN_Y;
      MAIN_Y:  phase_succ = RED1;
      RED1:    phase_succ = SIDE_G;
      SIDE_G:  phase_succ = SIDE_Y;
      SIDE_Y:  phase_succ = RED2;
      default: phase_succ = MAIN_G;
    endcase
  endfunction

  // Free-running prescaler; deliberately not restarted on phase changes.
  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;

  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  phase_t     r_phase;
  logic [7:0] r_rem;
  logic [2:0] r_main_lamp;
  logic [2:0] r_side_lamp;
  logic       r_walk;
  logic       r_walk_sel;

  phase_t     w_phase_next;
  logic [7:0] w_rem_next;
  logic [7:0] w_rem_dec;
  logic [2:0] w_main_next;
  logic [2:0] w_side_next;
  logic       w_walk_next;
  logic       w_walk_sel_next;
  logic       w_enter_side;
  logic       w_demand;

  logic r_x_meta;
  logic r_x_sync;
  logic r_car_pend;
  logic w_ped_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_meta <= 1'b0;
      r_x_sync <= 1'b0;
    end else begin
      r_x_meta <= x;
      r_x_sync <= r_x_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_car_pend <= 1'b0;
    end else if (w_enter_side) begin
      r_car_pend <= 1'b0;
    end else if ((r_phase != SIDE_G) && r_x_sync) begin
      r_car_pend <= 1'b1;
    end
  end

`ifdef TRAFFIC_PED_EN
  logic r_ped_meta;
  logic r_ped_sync;
  logic r_ped_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ped_meta <= 1'b0;
      r_ped_sync <= 1'b0;
      r_ped_pend <= 1'b0;
    end else begin
      r_ped_meta <= ped_req;
      r_ped_sync <= r_ped_meta;
      if (w_enter_side) begin
        r_ped_pend <= 1'b0;
      end else if ((r_phase != SIDE_G) && r_ped_sync) begin
        r_ped_pend <= 1'b1;
      end
    end
  end

  assign w_ped_pend = r_ped_pend;
`else
  // Button has no effect in this build; the walk path folds away to constant 0.
  assign w_ped_pend = 1'b0 & ped_req;
`endif

  assign w_demand = r_car_pend | w_ped_pend;

  // BCD decrement that saturates at 00.
  always_comb begin
    w_rem_dec = r_rem;
    if (r_rem[3:0] != 4'd0) begin
      w_rem_dec[3:0] = r_rem[3:0] - 4'd1;
    end else if (r_rem[7:4] != 4'd0) begin
      w_rem_dec[3:0] = 4'd9;
      w_rem_dec[7:4] = r_rem[7:4] - 4'd1;
    end
  end

  always_comb begin
    w_phase_next = r_phase;
    w_rem_next   = r_rem;
    if (w_tick) begin
      case (r_phase)
        MAIN_G: begin
          if (((r_rem == 8'h01) || (r_rem == 8'h00)) && w_demand) begin
            w_phase_next = MAIN_Y;
            w_rem_next   = phase_len(MAIN_Y);
          end else begin
            w_rem_next = w_rem_dec;
          end
        end
        MAIN_Y, RED1, SIDE_G, SIDE_Y, RED2: begin
          if (r_rem == 8'h01) begin
            w_phase_next = phase_succ(r_phase);
            w_rem_next   = phase_len(phase_succ(r_phase));
          end else begin
            w_rem_next = w_rem_dec;
          end
        end
        default: begin
          w_phase_next = MAIN_G;
          w_rem_next   = BCD_MAIN_G;
        end
      endcase
    end
  end

  // Lamps are decoded from the next phase so they register together with it.
  always_comb begin
    w_main_next = LAMP_R;
    w_side_next = LAMP_R;
    case (w_phase_next)
      MAIN_G:  w_main_next = LAMP_G;
      MAIN_Y:  w_main_next = LAMP_Y;
      SIDE_G:  w_side_next = LAMP_G;
      SIDE_Y:  w_side_next = LAMP_Y;
      default: begin
        w_main_next = LAMP_R;
        w_side_next = LAMP_R;
      end
    endcase
  end

  assign w_enter_side    = (r_phase != SIDE_G) && (w_phase_next == SIDE_G);
  assign w_walk_sel_next = w_enter_side ? w_ped_pend : r_walk_sel;
  assign w_walk_next     = (w_phase_next == SIDE_G) && w_walk_sel_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= MAIN_G;
      r_rem       <= BCD_MAIN_G;
      r_main_lamp <= LAMP_G;
      r_side_lamp <= LAMP_R;
      r_walk      <= 1'b0;
      r_walk_sel  <= 1'b0;
    end else begin
      r_phase     <= w_phase_next;
      r_rem       <= w_rem_next;
      r_main_lamp <= w_main_next;
      r_side_lamp <= w_side_next;
      r_walk      <= w_walk_next;
      r_walk_sel  <= w_walk_sel_next;
    end
  end

  assign main_lamp = r_main_lamp;
  assign side_lamp = r_side_lamp;
  assign walk      = r_walk;
  assign phase     = r_phase;
  assign num       = r_rem[3:0];
  assign num1      = r_rem[7:4];

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: per-edge expectations from a tick-level reference model,
// checked by an independent monitor one step after each rising edge.
module tb_traffic_phase_ctrl;

  localparam int TD = 4;
  localparam int MG = 5;
  localparam int YT = 2;
  localparam int AR = 1;
  localparam int SG = 3;

`ifdef TRAFFIC_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       x       = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       walk;
  logic [2:0] phase;
  logic [3:0] num;
  logic [3:0] num1;

  traffic_phase_ctrl #(
    .TICK_DIV    (TD),
    .MAIN_GREEN_T(MG),
    .YELLOW_T    (YT),
    .ALL_RED_T   (AR),
    .SIDE_GREEN_T(SG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .ped_req  (ped_req),
    .main_lamp(main_lamp),
    .side_lamp(side_lamp),
    .walk     (walk),
    .phase    (phase),
    .num      (num),
    .num1     (num1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] ml;
    logic [2:0] sl;
    logic       w;
    logic [7:0] bcd;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: phase index, remaining ticks as an integer, demand flags,
  // prescaler position and the last two pin samples (the synchronizer delay).
  int m_phase;
  int m_rem;
  int m_cnt;
  bit m_car;
  bit m_ped;
  bit m_wsel;
  bit px1, px2, pp1, pp2;

  function automatic int dur(input int p);
    case (p)
      0:       dur = MG;
      1, 4:    dur = YT;
      2, 5:    dur = AR;
      default: dur = SG;
    endcase
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.ph  = 3'(m_phase);
    e.ml  = (m_phase == 0) ? 3'b001 : (m_phase == 1) ? 3'b010 : 3'b100;
    e.sl  = (m_phase == 3) ? 3'b001 : (m_phase == 4) ? 3'b010 : 3'b100;
    e.w   = (m_phase == 3) && m_wsel;
    e.bcd = {4'(m_rem / 10), 4'(m_rem % 10)};
    return e;
  endfunction

  task automatic model_edge(input bit rv, input bit xv, input bit pv);
    bit tick;
    int old;
    bit dem;
    if (!rv) begin
      m_phase = 0; m_rem = MG; m_cnt = 0;
      m_car = 0; m_ped = 0; m_wsel = 0;
      px1 = 0; px2 = 0; pp1 = 0; pp2 = 0;
    end else begin
      tick = (m_cnt == TD - 1);
      old  = m_phase;
      dem  = m_car || m_ped;
      if (tick) begin
        if (m_phase == 0) begin
          if (m_rem <= 1 && dem) begin
            m_phase = 1;
            m_rem   = dur(1);
          end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
          end
        end else if (m_rem == 1) begin
          m_phase = (m_phase + 1) % 6;
          m_rem   = dur(m_phase);
        end else begin
          m_rem = m_rem - 1;
        end
      end
      if (old != 3 && m_phase == 3) begin
        m_wsel = m_ped;
        m_car  = 0;
        m_ped  = 0;
      end else if (old != 3) begin
        if (px2) m_car = 1;
        if (PED && pp2) m_ped = 1;
      end
      m_cnt = tick ? 0 : m_cnt + 1;
      px2 = px1; px1 = xv;
      pp2 = pp1; pp1 = pv;
    end
  endtask

  function automatic void check(input string nm, input exp_t e);
    exp_t g;
    g = '{ph: phase, ml: main_lamp, sl: side_lamp, w: walk, bcd: {num1, num}};
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t: got phase=%0d main=%b side=%b walk=%b cnt=%h, required phase=%0d main=%b side=%b walk=%b cnt=%h",
               nm, $time, g.ph, g.ml, g.sl, g.w, g.bcd, e.ph, e.ml, e.sl, e.w, e.bcd);
    end
  endfunction

  // One stimulus cycle: drive inputs at the falling edge and queue what the next rising edge must produce.
  task automatic cyc(input bit xv, input bit pv, input bit rv);
    @(negedge clk);
    x       = xv;
    ped_req = pv;
    rst_n   = rv;
    model_edge(rv, xv, pv);
    sb_q.push_back(cur_exp());
  endtask

  task automatic reset_now();
    exp_t e;
    @(negedge clk);
    rst_n   = 1'b0;
    x       = 1'b0;
    ped_req = 1'b0;
    model_edge(1'b0, 1'b0, 1'b0);
    e = cur_exp();
    sb_q.push_back(e);
    #1;
    check("async_reset", e);
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n;
    n = 0;
    while (m_phase != p && n < budget) begin
      cyc(1'b0, 1'b0, 1'b1);
      n++;
    end
    if (m_phase != p) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_phase: model phase=%0d, required %0d within %0d cycles", m_phase, p, budget);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("outputs", e);
      end
    end
  end

  initial begin : stimulus
    int len;
    bit xv, pv, rv;
    model_edge(1'b0, 1'b0, 1'b0);

    // Power-on reset, then no demand for 40 ticks.
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    repeat (40 * TD) cyc(1'b0, 1'b0, 1'b1);

    // Early demand: x pulsed during the first tick period.
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b1);
    repeat (20 * TD) cyc(1'b0, 1'b0, 1'b1);

    // Late demand: x raised after nine ticks.
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    repeat (9 * TD) cyc(1'b0, 1'b0, 1'b1);
    repeat (16 * TD) cyc(1'b1, 1'b0, 1'b1);
    repeat (4 * TD) cyc(1'b0, 1'b0, 1'b1);

    // Pedestrian-only request.
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    repeat (20 * TD) cyc(1'b0, 1'b0, 1'b1);

    // Demand raised only while side road is green must be ignored.
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b1);
    wait_phase(3, 200);
    repeat (3) cyc(1'b1, 1'b0, 1'b1);
    repeat (30 * TD) cyc(1'b0, 1'b0, 1'b1);

    // Reset asserted in the middle of side green.
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b1, 1'b1);
    wait_phase(3, 200);
    repeat (5) cyc(1'b0, 1'b0, 1'b1);
    reset_now();
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    repeat (8 * TD) cyc(1'b0, 1'b0, 1'b1);

    // Randomized input levels with occasional resets.
    for (int s = 0; s < 80; s++) begin
      len = $urandom_range(1, 40);
      xv  = ($urandom_range(0, 3) == 0);
      pv  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 25) != 0);
      if (!rv) len = 2;
      repeat (len) cyc(xv, pv, rv);
    end

    repeat (3) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
